memory_loader: RTL

MEMORY_LOADER -- requirements
Module: memory_loader

---
 rtl/memory_loader_pkg.sv | 30 +++
 rtl/memory_loader_if.sv | 27 ++
 rtl/memory_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/memory_loader_pkg.sv
// Shared types and constants for the host-driven memory loader.
package memory_loader_pkg;

  localparam int ADDR_W = 12;
  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  // Default host command bytes: 'L' loads memory, 'D' dumps it back.
  localparam logic [BYTE_W-1:0] DEF_LOAD_CMD = 8'h4C;
  localparam logic [BYTE_W-1:0] DEF_DUMP_CMD = 8'h44;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    CNT_H,
    CNT_L,
    LOAD_HI,
    LOAD_LO,
    WRITE,
    DUMP_HI,
    DUMP_LO
  } state_t;

  typedef enum logic {
    MODE_LOAD = 1'b0,
    MODE_DUMP = 1'b1
  } mode_t;

endpackage

// File: rtl/memory_loader_if.sv
// Host byte streams plus the memory_unit port, bundled for the loader.
interface memory_loader_if;
  import memory_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_enable;
  logic [WORD_W-1:0] mem_write_data;
  logic [WORD_W-1:0] memory_content;

  // Loader side.
  modport master (
    input  rx_data, rx_valid, tx_ready, memory_content,
    output rx_ready, tx_data, tx_valid, mem_address, mem_write_enable, mem_write_data
  );

  // Host and memory side.
  modport slave (
    output rx_data, rx_valid, tx_ready, memory_content,
    input  rx_ready, tx_data, tx_valid, mem_address, mem_write_enable, mem_write_data
  );
endinterface

// File: rtl/memory_loader.sv
// Byte-serial loader: a host streams a command, a 12-bit start address and a
// word count (minus one), then either writes 16-bit words into memory or reads
// them back high byte first.
module memory_loader
  import memory_loader_pkg::*;
#(
  parameter logic [BYTE_W-1:0] LOAD_CMD = DEF_LOAD_CMD,
  parameter logic [BYTE_W-1:0] DUMP_CMD = DEF_DUMP_CMD
) (
  input  logic            clk,
  input  logic            reset,
  memory_loader_if.master bus,
  output logic            busy,
  output logic            cmd_error
);

  state_t            r_state;
  state_t            w_next_state;
  mode_t             r_mode;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic [WORD_W-1:0] r_data;
  logic              r_cmd_error;

  logic              w_rx_ready;
  logic              w_tx_valid;
  logic [BYTE_W-1:0] w_tx_data;
  logic              w_write_enable;
  logic              w_rx_fire;
  logic              w_tx_fire;
  logic              w_is_load;
  logic              w_is_dump;
  logic              w_last;

  assign w_rx_fire = bus.rx_valid && w_rx_ready;
  assign w_tx_fire = w_tx_valid && bus.tx_ready;
  assign w_is_load = (bus.rx_data == LOAD_CMD);
  assign w_is_dump = (bus.rx_data == DUMP_CMD);
  assign w_last    = (r_remaining == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode: receive states advance on an accepted byte, dump
  // states on an accepted output byte, WRITE always takes exactly one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_rx_fire && (w_is_load || w_is_dump)) w_next_state = ADDR_H;
      ADDR_H:  if (w_rx_fire) w_next_state = ADDR_L;
      ADDR_L:  if (w_rx_fire) w_next_state = CNT_H;
      CNT_H:   if (w_rx_fire) w_next_state = CNT_L;
      CNT_L:   if (w_rx_fire) w_next_state = (r_mode == MODE_DUMP) ? DUMP_HI : LOAD_HI;
      LOAD_HI: if (w_rx_fire) w_next_state = LOAD_LO;
      LOAD_LO: if (w_rx_fire) w_next_state = WRITE;
      WRITE:   w_next_state = w_last ? IDLE : LOAD_HI;
      DUMP_HI: if (w_tx_fire) w_next_state = DUMP_LO;
      DUMP_LO: if (w_tx_fire) w_next_state = w_last ? IDLE : DUMP_HI;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode: tx bytes come straight from the combinational memory read,
  // so holding r_addr during a stall keeps tx_data stable.
  always_comb begin
    w_rx_ready     = 1'b0;
    w_tx_valid     = 1'b0;
    w_tx_data      = '0;
    w_write_enable = 1'b0;
    case (r_state)
      IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, LOAD_HI, LOAD_LO: w_rx_ready = 1'b1;
      WRITE:   w_write_enable = 1'b1;
      DUMP_HI: begin
        w_tx_valid = 1'b1;
        w_tx_data  = bus.memory_content[15:8];
      end
      DUMP_LO: begin
        w_tx_valid = 1'b1;
        w_tx_data  = bus.memory_content[7:0];
      end
      default: ;
    endcase
  end

  // Datapath registers: header fields, word assembly, address/count stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode      <= MODE_LOAD;
      r_addr      <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_cmd_error <= 1'b0;
    end else begin
      r_cmd_error <= (r_state == IDLE) && w_rx_fire && !w_is_load && !w_is_dump;
      case (r_state)
        IDLE: if (w_rx_fire) begin
          if (w_is_load)      r_mode <= MODE_LOAD;
          else if (w_is_dump) r_mode <= MODE_DUMP;
        end
        ADDR_H:  if (w_rx_fire) r_addr[11:8]      <= bus.rx_data[3:0];
        ADDR_L:  if (w_rx_fire) r_addr[7:0]       <= bus.rx_data;
        CNT_H:   if (w_rx_fire) r_remaining[11:8] <= bus.rx_data[3:0];
        CNT_L:   if (w_rx_fire) r_remaining[7:0]  <= bus.rx_data;
        LOAD_HI: if (w_rx_fire) r_data[15:8]      <= bus.rx_data;
        LOAD_LO: if (w_rx_fire) r_data[7:0]       <= bus.rx_data;
        WRITE: if (!w_last) begin
          r_addr      <= r_addr + 12'd1;
          r_remaining <= r_remaining - 12'd1;
        end
        DUMP_LO: if (w_tx_fire && !w_last) begin
          r_addr      <= r_addr + 12'd1;
          r_remaining <= r_remaining - 12'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready         = w_rx_ready;
  assign bus.tx_valid         = w_tx_valid;
  assign bus.tx_data          = w_tx_data;
  assign bus.mem_write_enable = w_write_enable;
  assign bus.mem_write_data   = r_data;
  assign bus.mem_address      = r_addr;
  assign busy                 = (r_state != IDLE);
  assign cmd_error            = r_cmd_error;

endmodule
